seq_detector_param: RTL and testbench

Parametrised serial pattern detector, the successor to the fixed 1100 Moore detectors.
- Pattern length, reset pattern and hit-counter width are parameters.
- Pattern can be reloaded at runtime.
- Overlapping or non-overlapping detection is selectable per cycle.
- Registered (Moore) match pulse plus a saturating hit counter.
- Sits between a serial bit source (Galois LFSR in benches, line receiver in designs) and status logic.

---
 rtl/seqdet_pkg.sv | 21 ++
 rtl/seqdet_window.sv | 39 +++
 rtl/seq_detector_param.sv | 99 +++++++++
 tb/tb_seq_detector_param.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// Shared types, default constants and helpers for the parametrised serial pattern detector.
// The optional SEQDET_MASK_EN build adds a per-bit compare mask, handled in the top level.
package seqdet_pkg;

    typedef enum logic {
        SEQ_NONOVL = 1'b0,
        SEQ_OVL    = 1'b1
    } seqdet_mode_e;

    localparam int unsigned SEQDET_N     = 4;
    localparam logic [3:0]  SEQDET_PAT   = 4'b1100;
    localparam int unsigned SEQDET_CNT_W = 8;

    // Increment that holds at the all-ones value of a width-bit counter
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'(1) << width) - 32'(1));
        return (count >= max_val) ? max_val : (count + 32'(1));
    endfunction

endpackage

// File: rtl/seqdet_window.sv
// Sample window of the last N bits plus a saturating count of how many of them are valid.
// Exposes the post-shift window and fill so the caller can decide a hit on the sampling edge.
module seqdet_window
    import seqdet_pkg::*;
#(
    parameter int unsigned N  = SEQDET_N,
    parameter int unsigned FW = $clog2(N + 1)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          shift,
    input  logic          flush,
    input  logic          restart,
    input  logic          x,
    output logic [N-1:0]  next_window,
    output logic [FW-1:0] next_fill
);

    logic [N-1:0]  r_window;
    logic [FW-1:0] r_fill;

    assign next_window = {r_window[N-2:0], x};
    assign next_fill   = (r_fill == FW'(N)) ? r_fill : (r_fill + FW'(1));

    // restart drops the fill after a non-overlapping hit so matched bits are not reused
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_window <= '0;
            r_fill   <= '0;
        end else if (flush) begin
            r_window <= '0;
            r_fill   <= '0;
        end else if (shift) begin
            r_window <= next_window;
            r_fill   <= restart ? '0 : next_fill;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector: runtime-loadable pattern, overlap select, registered
// match pulse and saturating hit counter. Define SEQDET_MASK_EN to add a don't-care mask.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int unsigned  N       = SEQDET_N,
    parameter logic [N-1:0] PATTERN = N'(SEQDET_PAT),
    parameter int unsigned  CNT_W   = SEQDET_CNT_W
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             x,
    input  logic             ovl,
    input  logic             load,
    input  logic [N-1:0]     pat_in,
`ifdef SEQDET_MASK_EN
    input  logic [N-1:0]     mask_in,
`endif
    input  logic             clr,
    output logic             y,
    output logic [CNT_W-1:0] hits,
    output logic [N-1:0]     pat
);

    localparam int unsigned FW = $clog2(N + 1);

    logic [N-1:0]     w_next_window;
    logic [FW-1:0]    w_next_fill;
    logic [N-1:0]     w_diff;
    logic             w_shift;
    logic             w_hit;
    logic             w_restart;
    seqdet_mode_e     w_mode;

    logic             r_y;
    logic [CNT_W-1:0] r_hits;
    logic [N-1:0]     r_pat;

    assign w_shift = en & ~load;
    assign w_mode  = seqdet_mode_e'(ovl);

    seqdet_window #(
        .N  (N),
        .FW (FW)
    ) u_window (
        .Clock       (Clock),
        .Reset       (Reset),
        .shift       (w_shift),
        .flush       (load),
        .restart     (w_restart),
        .x           (x),
        .next_window (w_next_window),
        .next_fill   (w_next_fill)
    );

`ifdef SEQDET_MASK_EN
    logic [N-1:0] r_mask;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_mask <= '1;
        end else if (load) begin
            r_mask <= mask_in;
        end
    end

    assign w_diff = (w_next_window ^ r_pat) & r_mask;
`else
    assign w_diff = w_next_window ^ r_pat;
`endif

    assign w_hit     = w_shift && (w_next_fill == FW'(N)) && (w_diff == '0);
    assign w_restart = w_hit && (w_mode == SEQ_NONOVL);

    // Load forces w_hit low, so y is cleared on a load edge as well as on idle edges
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_y    <= 1'b0;
            r_hits <= '0;
            r_pat  <= PATTERN;
        end else begin
            r_y <= w_hit;
            if (clr) begin
                r_hits <= '0;
            end else if (w_hit) begin
                r_hits <= CNT_W'(sat_inc(32'(r_hits), CNT_W));
            end
            if (load) begin
                r_pat <= pat_in;
            end
        end
    end

    assign y    = r_y;
    assign hits = r_hits;
    assign pat  = r_pat;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed scenarios plus random traffic, checked
// against a bit-history reference model. Define SEQDET_MASK_EN to exercise the mask build.
module tb_seq_detector_param;

    localparam int unsigned N     = 4;
    localparam logic [3:0]  PAT0  = 4'b1100;
    localparam int unsigned CNT_W = 8;
    localparam int          HMAX  = (1 << CNT_W) - 1;

    typedef struct {
        int         y;
        int         hits;
        logic [3:0] pat;
    } exp_t;

    logic             Clock;
    logic             Reset;
    logic             en;
    logic             x;
    logic             ovl;
    logic             load;
    logic [N-1:0]     pat_in;
    logic [N-1:0]     mask_in;
    logic             clr;
    logic             y;
    logic [CNT_W-1:0] hits;
    logic [N-1:0]     pat;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];

    // Reference model state: bits received since the last restart point, oldest first
    bit         m_hist[$];
    logic [3:0] m_pat;
    logic [3:0] m_mask;
    int         m_hits;

    seq_detector_param #(
        .N       (N),
        .PATTERN (PAT0),
        .CNT_W   (CNT_W)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .en      (en),
        .x       (x),
        .ovl     (ovl),
        .load    (load),
        .pat_in  (pat_in),
`ifdef SEQDET_MASK_EN
        .mask_in (mask_in),
`endif
        .clr     (clr),
        .y       (y),
        .hits    (hits),
        .pat     (pat)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_pat  = PAT0;
        m_mask = 4'hF;
        m_hits = 0;
    endtask

    task automatic model_step(input logic i_en, input logic i_x, input logic i_ovl,
                              input logic i_load, input logic [3:0] i_pat,
                              input logic [3:0] i_mask, input logic i_clr);
        exp_t       e;
        logic [3:0] v;
        int         hit;
        hit = 0;
        if (i_load) begin
            m_pat = i_pat;
`ifdef SEQDET_MASK_EN
            m_mask = i_mask;
`endif
            m_hist.delete();
        end else if (i_en) begin
            m_hist.push_back(i_x);
            if (m_hist.size() > N) void'(m_hist.pop_front());
            if (m_hist.size() == N) begin
                v = '0;
                foreach (m_hist[i]) v = {v[2:0], m_hist[i]};
                if (((v ^ m_pat) & m_mask) == 4'h0) begin
                    hit = 1;
                    if (!i_ovl) m_hist.delete();
                end
            end
        end
        if (i_clr) m_hits = 0;
        else if (hit != 0 && m_hits < HMAX) m_hits++;
        e.y    = hit;
        e.hits = m_hits;
        e.pat  = m_pat;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus; expectation is queued right after the sampling edge
    task automatic step(input logic i_en, input logic i_x, input logic i_ovl,
                        input logic i_load, input logic [3:0] i_pat,
                        input logic [3:0] i_mask, input logic i_clr);
        @(negedge Clock);
        en = i_en; x = i_x; ovl = i_ovl; load = i_load;
        pat_in = i_pat; mask_in = i_mask; clr = i_clr;
        @(posedge Clock);
        model_step(i_en, i_x, i_ovl, i_load, i_pat, i_mask, i_clr);
    endtask

    task automatic feed(input logic [31:0] bits, input int n, input logic o);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], o, 1'b0, 4'h0, 4'hF, 1'b0);
    endtask

    task automatic do_load(input logic [3:0] p, input logic [3:0] m);
        step(1'b1, 1'b1, 1'b1, 1'b1, p, m, 1'b0);
    endtask

    // Monitor: every registered output update is compared with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("y", int'(y), e.y);
                chk("hits", int'(hits), e.hits);
                chk("pat", int'(pat), int'(e.pat));
            end
        end
    end

    initial begin
        en = 0; x = 0; ovl = 1; load = 0; pat_in = 0; mask_in = 4'hF; clr = 0;
        Reset = 0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        chk("reset_y", int'(y), 0);
        chk("reset_hits", int'(hits), 0);
        chk("reset_pat", int'(pat), int'(PAT0));
        @(negedge Clock);
        Reset = 1;

        // Default pattern, overlapping
        feed(32'b1100_1100, 8, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);

        // 1010 with and without overlap
        do_load(4'b1010, 4'hF);
        feed(32'b101010, 6, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1);
        do_load(4'b1010, 4'hF);
        feed(32'b101010, 6, 1'b0);

        // Enable gating: idle edges interleaved must not shift
        do_load(4'b1100, 4'hF);
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, (i >= 2) ? 1'b1 : 1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
            step(1'b0, (i >= 2) ? 1'b0 : 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        end

        // Saturation of hits, then clear on a hit edge
        do_load(4'b1111, 4'hF);
        for (int i = 0; i < HMAX + 10; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'hF, 1'b0);

        // Asynchronous reset after a partial 110
        do_load(4'b1100, 4'hF);
        feed(32'b110, 3, 1'b1);
        @(negedge Clock);
        Reset = 0;
        #1;
        chk("async_y", int'(y), 0);
        chk("async_hits", int'(hits), 0);
        chk("async_pat", int'(pat), int'(PAT0));
        model_reset();
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1;
        feed(32'b0, 1, 1'b1);
        feed(32'b1100, 4, 1'b1);

`ifdef SEQDET_MASK_EN
        do_load(4'b1100, 4'b1001);
        feed(32'b1010, 4, 1'b0);
        do_load(4'b1100, 4'b1001);
        feed(32'b0100, 4, 1'b0);
        do_load(4'b1100, 4'hF);
`endif

        // Random traffic with occasional reloads and clears
        for (int i = 0; i < 600; i++) begin
            logic r_load, r_clr;
            logic [3:0] r_pat, r_mask;
            r_load = ($urandom_range(0, 24) == 0);
            r_clr  = ($urandom_range(0, 39) == 0);
            r_pat  = 4'($urandom);
`ifdef SEQDET_MASK_EN
            r_mask = 4'($urandom) | 4'b1000;
`else
            r_mask = 4'hF;
`endif
            step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), r_load,
                 r_pat, r_mask, r_clr);
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clock);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
